// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Bundles the request/response handshake and the byte-masked data memory
// port of the load/store unit.
//   req_*  : core -> unit request (req_ready driven by the unit)
//   rsp_*  : unit -> core response (rsp_ready driven by the core)
//   mem_*  : unit -> data memory (mem_rd driven by the memory, combinational)
// Handshake semantics: a request transfers on a rising clk edge where
// req_valid && req_ready; a response transfers on a rising edge where
// rsp_valid && rsp_ready. The producer holds rsp_valid/rsp_rdata/rsp_fault
// stable until the transfer. Request fields need only be valid at the
// accepting edge.
// Modports:
//   master : the environment side (core plus data memory)
//   slave  : the load/store unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [3:0]  mem_wm;
  logic [31:0] mem_rd;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_a, mem_wd, mem_we, mem_wm
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_a, mem_wd, mem_we, mem_wm
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// RV32I load/store unit between the memory stage and a byte-masked data
// memory. One request is handled at a time through IDLE -> ACCESS -> RESP.
// Stores drive a byte write mask and lane-replicated data for exactly one
// cycle; loads extract and sign/zero-extend the addressed byte/half/word.
// Misaligned accesses and illegal funct3 values are reported as faults and
// never touch memory.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high
//   bus       : load_store_unit_if.slave (request, response, memory port)
//   dbg_state : current FSM state (IDLE=00, ACCESS=01, RESP=10)
module load_store_unit (
  input  logic                     clk,
  input  logic                     reset,
  load_store_unit_if.slave         bus,
  output logic [1:0]               dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  logic [1:0]  state;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rsp_rdata_q;
  logic        rsp_fault_q;

  logic        fault;
  logic [1:0]  off;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign off = lat_addr[1:0];

  // Fault decode on the latched request.
  always_comb begin
    fault = 1'b0;
    case (lat_f3)
      3'b000, 3'b100: fault = 1'b0;
      3'b001, 3'b101: fault = lat_addr[0];
      3'b010:         fault = |lat_addr[1:0];
      default:        fault = 1'b1;
    endcase
    // Unsigned variants only exist for loads.
    if (lat_we && lat_f3[2]) fault = 1'b1;
  end

  // Store lane mask and replicated write data. The memory picks the
  // correct lanes through the mask, so replication avoids a shifter.
  always_comb begin
    st_mask = 4'b1111;
    st_data = lat_wdata;
    case (lat_f3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << off;
        st_data = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        st_mask = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{lat_wdata[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = lat_wdata;
      end
    endcase
  end

  // Load lane extraction and extension.
  always_comb begin
    case (off)
      2'b00:   ld_byte = bus.mem_rd[7:0];
      2'b01:   ld_byte = bus.mem_rd[15:8];
      2'b10:   ld_byte = bus.mem_rd[23:16];
      default: ld_byte = bus.mem_rd[31:24];
    endcase
    ld_half = off[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
    case (lat_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = bus.mem_rd;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      lat_we      <= 1'b0;
      lat_f3      <= 3'b000;
      lat_addr    <= 32'h0;
      lat_wdata   <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_fault_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            lat_we    <= bus.req_we;
            lat_f3    <= bus.req_funct3;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (fault) begin
            rsp_rdata_q <= 32'h0;
            rsp_fault_q <= 1'b1;
          end else begin
            rsp_rdata_q <= lat_we ? 32'h0 : ld_data;
            rsp_fault_q <= 1'b0;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // req_ready is gated by reset so the core never sees a ready unit while
  // reset is still asserted.
  assign bus.req_ready = (state == ST_IDLE) && !reset;
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.mem_a     = lat_addr;
  assign bus.mem_wd    = st_data;
  assign bus.mem_we    = (state == ST_ACCESS) && lat_we && !fault;
  assign bus.mem_wm    = bus.mem_we ? st_mask : 4'b0000;
  assign dbg_state     = state;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if bus();
  logic [1:0] dbg_state;

  load_store_unit dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- data memory (word array driven by the DUT port) -------
  logic [31:0] mem_words [64];
  assign bus.mem_rd = mem_words[bus.mem_a[7:2]];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_wm[i]) mem_words[bus.mem_a[7:2]][8*i +: 8] <= bus.mem_wd[8*i +: 8];
    end
  end

  // ---------------- reference model: flat byte memory ----------------
  logic [7:0]  ref_bytes [256];
  logic [31:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    return (int'(a[1:0]) % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = size_of(f3);
    v = 32'h0;
    for (int k = 0; k < n; k++)
      v = v | (32'(ref_bytes[(int'(a[7:0]) + k) & 255]) << (8 * k));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m;
    m = 4'b0000;
    for (int k = 0; k < size_of(f3); k++) m[int'(a[1:0]) + k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < size_of(f3); k++)
      ref_bytes[(int'(a[7:0]) + k) & 255] = d[8*k +: 8];
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input bit poke);
    bit          flt;
    bit          wr;
    logic [31:0] e;
    int          t;
    t = 0;
    while (!bus.req_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("req_ready_idle", bus.req_ready, 1'b1);
    flt = model_fault(we, f3, addr);
    wr  = we && !flt;
    exp_q.push_back((we || flt) ? 32'h0 : model_load(f3, addr));

    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk); #1;
    // request inputs are only needed at the accepting edge
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom_range(0, 1));
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    // rsp_ready during ACCESS must not matter
    bus.rsp_ready  = 1'($urandom_range(0, 1));

    chk("access_req_ready", bus.req_ready, 1'b0);
    chk("access_rsp_valid", bus.rsp_valid, 1'b0);
    chk("mem_a", bus.mem_a, addr);
    chk("mem_we", bus.mem_we, wr);
    chk("mem_wm", bus.mem_wm, wr ? model_mask(f3, addr) : 4'b0000);
    if (wr) begin
      chk("mem_wd", bus.mem_wd, model_wd(f3, wdata));
      model_store(f3, addr, wdata);
    end

    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    e = exp_q.pop_front();
    chk("rsp_valid", bus.rsp_valid, 1'b1);
    chk("rsp_rdata", bus.rsp_rdata, e);
    chk("rsp_fault", bus.rsp_fault, flt);
    chk("resp_mem_we", bus.mem_we, 1'b0);
    chk("resp_mem_wm", bus.mem_wm, 4'b0000);

    for (int h = 0; h < hold; h++) begin
      if (poke && h == 0) begin
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr  = 32'h0000_0040;
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("hold_rsp_valid", bus.rsp_valid, 1'b1);
      chk("hold_rsp_rdata", bus.rsp_rdata, e);
      chk("hold_rsp_fault", bus.rsp_fault, flt);
      chk("hold_req_ready", bus.req_ready, 1'b0);
      chk("hold_mem_we", bus.mem_we, 1'b0);
    end

    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("done_rsp_valid", bus.rsp_valid, 1'b0);
    chk("done_req_ready", bus.req_ready, 1'b1);
  endtask

  // Store whose ACCESS cycle is cut by reset: it must not reach memory.
  task automatic reset_during_store(input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rst_pre_mem_we", bus.mem_we, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_wm", bus.mem_wm, 4'b0000);
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    @(posedge clk); #1;
    chk("rst_edge_rsp_valid", bus.rsp_valid, 1'b0);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("rst_rel_req_ready", bus.req_ready, 1'b1);
    chk("rst_rel_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rel_rsp_rdata", bus.rsp_rdata, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;

    for (int i = 0; i < 64; i++) mem_words[i] = 32'h0;
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h0;
    mem_words[8]    = 32'h80FF_7F01;
    ref_bytes[8'h20] = 8'h01;
    ref_bytes[8'h21] = 8'h7F;
    ref_bytes[8'h22] = 8'hFF;
    ref_bytes[8'h23] = 8'h80;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", bus.req_ready, 1'b0);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_rsp_fault", bus.rsp_fault, 1'b0);
    chk("reset_mem_a", bus.mem_a, 32'h0);
    chk("reset_mem_wd", bus.mem_wd, 32'h0);
    chk("reset_mem_we", bus.mem_we, 1'b0);
    chk("reset_mem_wm", bus.mem_wm, 4'b0000);
    @(negedge clk) reset = 1'b0;
    #1;
    chk("post_reset_req_ready", bus.req_ready, 1'b1);

    // byte store to the top lane
    do_req(1'b1, 3'b000, 32'h0000_0013, 32'hAABB_CC5A, 0, 1'b0);
    // extraction/extension from word 0x80FF7F01
    do_req(1'b0, 3'b000, 32'h0000_0021, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'b000, 32'h0000_0022, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'b100, 32'h0000_0023, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'b001, 32'h0000_0022, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'b101, 32'h0000_0022, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'b010, 32'h0000_0020, 32'h0, 0, 1'b0);
    chk("lw_0x20_const", mem_words[8], 32'h80FF_7F01);
    // upper-half store then word read-back
    do_req(1'b0, 3'b010, 32'h0000_0030, 32'h0, 0, 1'b0);
    do_req(1'b1, 3'b001, 32'h0000_0032, 32'h0000_1234, 0, 1'b0);
    do_req(1'b0, 3'b010, 32'h0000_0030, 32'h0, 0, 1'b0);
    chk("sh_upper_const", {16'h0, mem_words[12][31:16]}, 32'h0000_1234);
    // faults
    do_req(1'b1, 3'b010, 32'h0000_0036, 32'hDEAD_BEEF, 0, 1'b0);
    do_req(1'b0, 3'b001, 32'h0000_0031, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'b011, 32'h0000_0040, 32'h0, 0, 1'b0);
    do_req(1'b1, 3'b100, 32'h0000_0044, 32'h1111_2222, 0, 1'b0);
    // response back-pressure with an ignored request pulse
    do_req(1'b0, 3'b010, 32'h0000_0020, 32'h0, 5, 1'b1);
    // reset in the middle of a store
    reset_during_store(32'h0000_0040, 32'hCAFE_F00D);
    do_req(1'b0, 3'b010, 32'h0000_0040, 32'h0, 0, 1'b0);

    // randomized traffic, biased toward aligned addresses
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(size_of(f3)) - 1);
      do_req(we, f3, a, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // final cross-check of the whole memory image
    for (int w = 0; w < 64; w++)
      chk("mem_image", mem_words[w],
          {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
